// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory arbiter
package dm_arb_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  typedef enum logic [2:0] {IDLE, ACC, RMW, MRG, DONE} state_t;
endpackage

// File: rtl/dm_byte_merge.sv
// dm_byte_merge: per-byte select between an old word and a new word by byte enable
// Ports: old_i (current word), new_i (lane-positioned data), be_i (1 = take new lane), merged_o (result)
module dm_byte_merge import dm_arb_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0]   old_i,
  input  logic [DW-1:0]   new_i,
  input  logic [DW/8-1:0] be_i,
  output logic [DW-1:0]   merged_o
);
  for (genvar i = 0; i < DW/8; i++) begin : g_lane
    assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8] : old_i[8*i +: 8];
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer for dm_1k with word alignment and read-modify-write for partial stores
// Ports: p0_* CPU load/store port, p1_* debug/loader port (req/we/be/addr/wdata in, ack/rdata out);
//        dm_addr/dm_din/dm_we/dm_dout memory side; busy high whenever not IDLE; clk, rst (async, active-high).
// Build option: DM_ARB_FIXED_PRIO_EN makes port 0 win every tie instead of round-robin.
module dm_arbiter import dm_arb_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);
  state_t state_q, state_d;
  logic last_q, last_d, win_q, win_d, we_q, we_d, win;
  logic [3:0] be_q, be_d, sel_be;
  logic [AW-1:0] addr_q, addr_d, sel_addr;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d, old_q, old_d, merged;
`ifdef DM_ARB_FIXED_PRIO_EN
  assign win = p0_req ? PORT_CPU : PORT_DBG;
`else
  assign win = (p0_req && p1_req) ? ~last_q : (p1_req ? PORT_DBG : PORT_CPU);
`endif
  assign sel_be = win ? p1_be : p0_be;
  assign sel_addr = win ? p1_addr : p0_addr;
  dm_byte_merge #(.DW(DW)) u_merge (
    .old_i(old_q),
    .new_i(wdata_q),
    .be_i(be_q),
    .merged_o(merged)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    win_d = win_q;
    we_d = we_q;
    be_d = be_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    old_d = old_q;
    unique case (state_q)
      IDLE: if (p0_req || p1_req) begin
        win_d = win;
        last_d = win;
        we_d = win ? p1_we : p0_we;
        be_d = sel_be;
        addr_d = sel_addr & ~AW'(3);
        wdata_d = win ? p1_wdata : p0_wdata;
        rdata_d = '0;
        state_d = (!we_d || sel_be == BE_FULL) ? ACC : (sel_be == '0) ? DONE : RMW;
      end
      ACC: begin
        rdata_d = we_q ? rdata_q : dm_dout;
        state_d = DONE;
      end
      RMW: begin
        old_d = dm_dout;
        state_d = MRG;
      end
      MRG: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= PORT_DBG;
      win_q <= PORT_CPU;
      we_q <= 1'b0;
      be_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      old_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      win_q <= win_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      old_q <= old_d;
    end
  end
  // memory strobes depend only on registered state and the latched request, so they cannot glitch
  assign dm_addr = addr_q;
  assign dm_we = (state_q == ACC && we_q) || state_q == MRG;
  assign dm_din = (state_q == MRG) ? merged : (state_q == ACC && we_q) ? wdata_q : '0;
  assign p0_ack = state_q == DONE && win_q == PORT_CPU;
  assign p1_ack = state_q == DONE && win_q == PORT_DBG;
  assign p0_rdata = p0_ack ? rdata_q : '0;
  assign p1_rdata = p1_ack ? rdata_q : '0;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized check of dm_arbiter against a transaction-level model
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack, dm_we, busy;
  logic [3:0] p0_be, p1_be;
  logic [9:0] p0_addr, p1_addr, dm_addr;
  logic [31:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, dm_din, dm_dout;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int n_chk = 0;
  int n_fail = 0;
  bit m_act, m_port, m_we, m_last, exp_ack0, exp_ack1, w;
  int m_k, m_L, m_wecnt;
  logic [3:0] m_be;
  logic [7:0] m_idx;
  logic [31:0] m_wd, m_rd;
  always #5 clk = ~clk;
  dm_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout), .busy(busy)
  );
  assign dm_dout = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge_w(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction
  // transaction-level model: a grant starts a fixed-length busy window whose last cycle is the ack
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
      m_last = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_acks", {p0_ack, p1_ack}, 0);
      chk("rst_p0_rdata", p0_rdata, 0);
      chk("rst_p1_rdata", p1_rdata, 0);
      chk("rst_dm_we", dm_we, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_din", dm_din, 0);
    end else begin
      exp_ack0 = m_act && m_k == m_L && !m_port;
      exp_ack1 = m_act && m_k == m_L && m_port;
      chk("busy", busy, m_act);
      chk("p0_ack", p0_ack, exp_ack0);
      chk("p1_ack", p1_ack, exp_ack1);
      chk("p0_rdata", p0_rdata, (exp_ack0 && !m_we) ? m_rd : 32'h0);
      chk("p1_rdata", p1_rdata, (exp_ack1 && !m_we) ? m_rd : 32'h0);
      if (m_act) chk("dm_addr", dm_addr, {m_idx, 2'b00});
      if (dm_we) begin
        chk("dm_we_legal", m_act && m_we && m_be != 4'h0, 1);
        m_wecnt++;
      end else chk("dm_din_idle", dm_din, 0);
      if (m_act && m_k == m_L) begin
        chk("we_count", m_wecnt, (m_we && m_be != 4'h0) ? 1 : 0);
        if (m_we) ref_mem[m_idx] = merge_w(ref_mem[m_idx], m_wd, m_be);
        chk("mem_word", mem[m_idx], ref_mem[m_idx]);
        m_act = 1'b0;
      end else if (m_act) m_k++;
      else if (p0_req || p1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        w = !p0_req;
`else
        w = (p0_req && p1_req) ? !m_last : p1_req;
`endif
        m_port = w;
        m_last = w;
        m_we = w ? p1_we : p0_we;
        m_be = w ? p1_be : p0_be;
        m_idx = w ? p1_addr[9:2] : p0_addr[9:2];
        m_wd = w ? p1_wdata : p0_wdata;
        m_L = !m_we ? 2 : (m_be == 4'h0) ? 1 : (m_be == 4'hF) ? 2 : 3;
        m_rd = ref_mem[m_idx];
        m_k = 1;
        m_wecnt = 0;
        m_act = 1'b1;
      end
    end
  end
  task automatic drive(input bit p, input bit rq, input bit we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd);
    if (!p) begin
      p0_req = rq; p0_we = we; p0_be = be; p0_addr = a; p0_wdata = wd;
    end else begin
      p1_req = rq; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = wd;
    end
  endtask
  task automatic rand_req(input bit p);
    int s;
    s = $urandom_range(0, 3);
    drive(p, 1'b1, 1'($urandom), (s == 0) ? 4'h0 : (s == 1) ? 4'hF : 4'($urandom),
          10'($urandom), $urandom);
  endtask
  task automatic txn(input bit p, input bit we, input logic [3:0] be, input logic [9:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic [9:0] acc_addr);
    lat = -1;
    rd = '0;
    acc_addr = '0;
    drive(p, 1'b1, we, be, a, wd);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #2;
      if (c == 1) acc_addr = dm_addr;
      if (p ? p1_ack : p0_ack) begin
        lat = c;
        rd = p ? p1_rdata : p0_rdata;
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    @(posedge clk); #2;
  endtask
  initial begin
    int lat, a0, a0b, a1, ac;
    logic [31:0] rd;
    logic [9:0] aa;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'hA1B2C3D4;
    ref_mem[4] = 32'hA1B2C3D4;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    // tie after reset; port 0 re-requests at its ack to contend again
    a0 = -1; a0b = -1; a1 = -1;
    drive(0, 1, 0, 4'hF, 10'h020, 0);
    drive(1, 1, 0, 4'hF, 10'h024, 0);
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #2;
      if (p0_ack) begin
        if (a0 < 0) a0 = c;
        else begin
          a0b = c;
          drive(0, 0, 0, 0, 0, 0);
        end
      end
      if (p1_ack) begin
        a1 = c;
        drive(1, 0, 0, 0, 0, 0);
      end
      if (a0b > 0 && a1 > 0) break;
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("tie_p0_first", a0, 2);
`ifdef DM_ARB_FIXED_PRIO_EN
    chk("tie_p0_again", a0b, 5);
    chk("tie_p1_last", a1, 8);
`else
    chk("tie_p1_next", a1, 5);
    chk("tie_p0_after", a0b, 8);
`endif
    @(posedge clk); #2;
    txn(0, 0, 4'hF, 10'h013, 0, lat, rd, aa);
    chk("rd_latency", lat, 2);
    chk("rd_data", rd, 32'hA1B2C3D4);
    chk("rd_acc_addr", aa, 10'h010);
    txn(1, 1, 4'h2, 10'h010, 32'h0000EE00, lat, rd, aa);
    chk("pw_latency", lat, 3);
    chk("pw_word", mem[4], 32'hA1B2EED4);
    txn(0, 1, 4'hF, 10'h3FC, 32'hDEADBEEF, lat, rd, aa);
    chk("fw_latency", lat, 2);
    txn(1, 0, 4'hF, 10'h3FE, 0, lat, rd, aa);
    chk("fw_readback", rd, 32'hDEADBEEF);
    txn(0, 1, 4'h0, 10'h010, 32'hFFFFFFFF, lat, rd, aa);
    chk("be0_latency", lat, 1);
    chk("be0_word", mem[4], 32'hA1B2EED4);
    // reset while the read half of a read-modify-write is in flight
    drive(0, 1, 1, 4'h1, 10'h010, 32'h00000055);
    @(posedge clk); #2;
    chk("rmw_busy", busy, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rmw_rst_busy", busy, 0);
    chk("rmw_rst_we", dm_we, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    ac = 0;
    repeat (4) begin
      @(posedge clk); #2;
      ac += int'(p0_ack);
    end
    chk("rmw_rst_no_ack", ac, 0);
    chk("rmw_rst_word", mem[4], 32'hA1B2EED4);
    for (int cy = 0; cy < 2000; cy++) begin
      @(posedge clk); #2;
      for (int p = 0; p < 2; p++) begin
        if ((p ? p1_req : p0_req) && (p ? p1_ack : p0_ack)) begin
          if ($urandom_range(0, 2) == 0) rand_req(1'(p));
          else drive(1'(p), 0, 0, 0, 0, 0);
        end else if (!(p ? p1_req : p0_req) && $urandom_range(0, 3) == 0) rand_req(1'(p));
      end
    end
    for (int c = 0; c < 50 && (p0_req || p1_req); c++) begin
      @(posedge clk); #2;
      if (p0_ack) drive(0, 0, 0, 0, 0, 0);
      if (p1_ack) drive(1, 0, 0, 0, 0, 0);
    end
    chk("drain", {p0_req, p1_req}, 0);
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 1 KB byte-addressed data memory (`dm_1k`).
- Port 0 is the CPU load/store unit; port 1 is a debug/loader master.
- Grants the memory to one requester at a time and aligns addresses to words.
- Performs read-modify-write for partial (byte/halfword) stores, since the memory only writes full 32-bit words.

Parameters:
- AW, 10, byte address width of the memory.
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_be  in  4  port 0 byte enables; bit i selects byte i (bits [8i+7:8i]).
- p0_addr  in  AW  port 0 byte address.
- p0_wdata  in  DW  port 0 write data, byte lanes already positioned.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DW  read word; valid while p0_ack=1.
- p1_req, p1_we, p1_be, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- dm_addr  out  AW  memory address.
- dm_din  out  DW  memory write data.
- dm_we  out  1  memory write enable.
- dm_dout  in  DW  memory read data; combinational from dm_addr.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (immediate on rst):
  - state=IDLE; last_grant=1.
  - All ack=0, all rdata=0, busy=0.
  - dm_we=0, dm_addr=0, dm_din=0.
- Request/signal stability:
  - req/we/be/addr/wdata must be stable from req rise until ack.
  - ack is registered, high exactly one cycle.
  - A req still high in the cycle after ack is treated as a new request.
- Address alignment:
  - Latched address is {addr[AW-1:2],2'b00}; addr[1:0] is ignored.
  - dm_addr never exceeds 1020, so addr+3 never leaves the array.
- States:
  - IDLE: if any req, select the winner (see arbitration); latch we/be/addr/wdata and the winner id; last_grant<=winner.
    - Read, or write with be=4'hF: go to ACC.
    - Write with be=4'h0: go to DONE (no memory access).
    - Other write: go to RMW.
  - ACC: drive dm_addr.
    - Read: rdata_q<=dm_dout, dm_we=0.
    - Full write: dm_din=wdata, dm_we=1.
    - Go to DONE.
  - RMW: drive dm_addr; old_q<=dm_dout; dm_we=0; go to MRG.
  - MRG: dm_din = byte i ? wdata byte i : old_q byte i, selected by be[i]; dm_we=1; go to DONE.
  - DONE: winner's ack=1; winner's rdata=rdata_q (0 for writes); go to IDLE.
- Latency (IDLE sampling edge to ack-high cycle):
  - Read or full write: 2 cycles.
  - Partial write: 3 cycles.
  - be=0 write: 1 cycle.
  - Maximum throughput per port: one read per 3 cycles.
- Arbitration:
  - Round-robin. With both reqs high in IDLE, grant the port != last_grant.
  - After reset, port 0 wins the first tie.
  - A single requester is always granted.
  - The loser waits; it is never starved (served next, within ≤4 cycles after the winner's ack).
- dm_addr/dm_din/dm_we are decoded from the state register and latched request only; they are glitch-free.
  - Outside ACC/MRG: dm_we=0, dm_din=0; dm_addr holds the latched address.
- Reset mid-operation:
  - Any state returns to IDLE and no ack is issued.
  - Reset asserted before the MRG edge leaves memory unchanged.
  - The requester must re-issue.
- The non-winning port's ack stays 0; its rdata holds 0.

Optional Feature:
- Macro: DM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins ties; last_grant is unused; port 1 can starve while p0_req stays high.
- Undefined: round-robin as above.

Decomposition:
- Package dm_arb_pkg:
  - state enum {IDLE, ACC, RMW, MRG, DONE}.
  - Constant BE_FULL=4'hF.
  - Constant PORT_CPU=0, PORT_DBG=1.
  - AW/DW defaults.
- Sub-module dm_byte_merge: combinational 4-lane merge of old word, new word and be; reusable for the load/store unit's sub-word handling.

Test Plan:
- Port 0 read addr=0x013 after memory preloaded with 0xA1B2C3D4 at 0x010: dm_addr=0x010 in ACC; p0_ack 2 cycles later; p0_rdata=0xA1B2C3D4.
- Port 1 write be=4'h2, wdata=0x0000EE00, addr=0x010 over 0xA1B2C3D4: one cycle dm_we; word becomes 0xA1B2EED4; p1_ack at cycle 3.
- Both req in the same cycle after reset, reads: port 0 acked first, port 1 acked 3 cycles later. Repeat the tie: port 1 first. With DM_ARB_FIXED_PRIO_EN: port 0 first both times.
- Full write addr=0x3FC wdata=0xDEADBEEF, then read back: 0xDEADBEEF; no access outside 0x3FC–0x3FF.
- Write be=4'h0: p0_ack after 1 cycle; dm_we never asserted; memory unchanged.
- rst pulsed in RMW during be=4'h1 write: state=IDLE; no ack; dm_we=0; target word unchanged; busy=0.
